// File: rtl/asi_pkg.sv
// Shared constants and types for the ASI slave write path: burst types,
// legal wrap lengths, transfer sizes and the per-beat record.
package asi_pkg;

  localparam int AXI_AW    = 40;
  localparam int AXI_IW    = 8;
  localparam int AXI_LW    = 8;
  localparam int AXI_SW    = 3;
  localparam int SLV_BYTES = 16;

  localparam logic [1:0] BT_FIXED    = 2'b00;
  localparam logic [1:0] BT_INCR     = 2'b01;
  localparam logic [1:0] BT_WRAP     = 2'b10;
  localparam logic [1:0] BT_RESERVED = 2'b11;

  // Wrap lengths are expressed as AxLEN values (beats - 1).
  localparam logic [7:0] WRAP_BL_2  = 8'd1;
  localparam logic [7:0] WRAP_BL_4  = 8'd3;
  localparam logic [7:0] WRAP_BL_8  = 8'd7;
  localparam logic [7:0] WRAP_BL_16 = 8'd15;

  localparam logic [2:0] TRSIZE_1   = 3'd0;
  localparam logic [2:0] TRSIZE_2   = 3'd1;
  localparam logic [2:0] TRSIZE_4   = 3'd2;
  localparam logic [2:0] TRSIZE_8   = 3'd3;
  localparam logic [2:0] TRSIZE_16  = 3'd4;
  localparam logic [2:0] TRSIZE_32  = 3'd5;
  localparam logic [2:0] TRSIZE_64  = 3'd6;
  localparam logic [2:0] TRSIZE_128 = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } wbeat_state_e;

  typedef struct packed {
    logic [AXI_IW-1:0]    id;
    logic [AXI_AW-1:0]    addr;
    logic [SLV_BYTES-1:0] mask;
    logic [AXI_LW-1:0]    idx;
    logic                 last;
    logic                 err;
  } asi_beat_t;

endpackage

// File: rtl/asi_beat_addr.sv
// Combinational AXI beat arithmetic: address of the following beat and the
// byte-lane mask of the current beat for FIXED, INCR and WRAP bursts.
module asi_beat_addr
  import asi_pkg::*;
#(
  parameter int AW     = AXI_AW,
  parameter int LW     = AXI_LW,
  parameter int SW     = AXI_SW,
  parameter int NBYTES = SLV_BYTES
) (
  input  logic [AW-1:0]     addr,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [LW-1:0]     len,
  input  logic [SW-1:0]     size,
  input  logic [1:0]        burst,
  output logic [AW-1:0]     next_addr,
  output logic [NBYTES-1:0] mask
);

  localparam int            LB  = $clog2(NBYTES);
  localparam logic [AW-1:0] ONE = AW'(1);

  logic [AW-1:0] sz_bytes;
  logic [AW-1:0] aligned;
  logic [AW-1:0] incr_addr;
  logic [AW-1:0] wbytes;
  logic [AW-1:0] lower;
  int            lo;
  int            hi;

  always_comb begin
    sz_bytes  = ONE << size;
    aligned   = addr & ~(sz_bytes - ONE);
    incr_addr = aligned + sz_bytes;
    wbytes    = (AW'(len) + ONE) << size;
    lower     = cmd_addr & ~(wbytes - ONE);

    case (burst)
      BT_FIXED: next_addr = cmd_addr;
      BT_WRAP:  next_addr = (incr_addr == (lower + wbytes)) ? lower : incr_addr;
      default:  next_addr = incr_addr;
    endcase
  end

  // Lanes run from the (possibly unaligned) start byte up to the end of the
  // size-aligned container, clipped at the top of the data bus.
  always_comb begin
    mask = '0;
    lo   = int'(addr[LB-1:0]);
    if (int'(size) >= LB) begin
      hi = NBYTES;
    end else begin
      hi = int'(aligned[LB-1:0]) + int'(sz_bytes[LB:0]);
    end
    for (int i = 0; i < NBYTES; i++) begin
      mask[i] = (i >= lo) && (i < hi);
    end
  end

endmodule

// File: rtl/asi_wbeat_gen.sv
// Expands one accepted AW command into a stream of per-beat address, lane
// mask and last flag. ASI_ADDR_CHECK_EN enables the illegal-command check.
module asi_wbeat_gen #(
  parameter int AXI_AW    = asi_pkg::AXI_AW,
  parameter int AXI_IW    = asi_pkg::AXI_IW,
  parameter int AXI_LW    = asi_pkg::AXI_LW,
  parameter int AXI_SW    = asi_pkg::AXI_SW,
  parameter int SLV_BYTES = asi_pkg::SLV_BYTES
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [AXI_IW-1:0]    cmd_id,
  input  logic [AXI_AW-1:0]    cmd_addr,
  input  logic [AXI_LW-1:0]    cmd_len,
  input  logic [AXI_SW-1:0]    cmd_size,
  input  logic [1:0]           cmd_burst,
  output logic                 beat_valid,
  input  logic                 beat_ready,
  output logic [AXI_IW-1:0]    beat_id,
  output logic [AXI_AW-1:0]    beat_addr,
  output logic [SLV_BYTES-1:0] beat_mask,
  output logic [AXI_LW-1:0]    beat_idx,
  output logic                 beat_last,
  output logic                 beat_err
);

  import asi_pkg::*;

  wbeat_state_e        state_q, state_d;
  logic [AXI_IW-1:0]   id_q, id_d;
  logic [AXI_AW-1:0]   addr_q, addr_d;
  logic [AXI_AW-1:0]   base_q, base_d;
  logic [AXI_LW-1:0]   len_q, len_d;
  logic [AXI_LW-1:0]   idx_q, idx_d;
  logic [AXI_SW-1:0]   size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic                last_q, last_d;

  logic [AXI_AW-1:0]    next_addr;
  logic [SLV_BYTES-1:0] lane_mask;
  logic                 beat_hs;
  logic                 cmd_hs;

  asi_beat_addr #(
    .AW     (AXI_AW),
    .LW     (AXI_LW),
    .SW     (AXI_SW),
    .NBYTES (SLV_BYTES)
  ) u_beat_addr (
    .addr      (addr_q),
    .cmd_addr  (base_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr),
    .mask      (lane_mask)
  );

  // Accepting during the final beat handshake keeps bursts back to back.
  assign beat_valid = (state_q == ST_BURST);
  assign beat_hs    = beat_valid & beat_ready;
  assign cmd_ready  = (state_q == ST_IDLE) | (beat_hs & last_q);
  assign cmd_hs     = cmd_valid & cmd_ready;

  assign beat_id   = id_q;
  assign beat_addr = addr_q;
  assign beat_idx  = idx_q;
  assign beat_last = last_q;
  assign beat_mask = beat_valid ? lane_mask : '0;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    size_d  = size_q;
    burst_d = burst_q;
    last_d  = last_q;

    if (cmd_hs) begin
      state_d = ST_BURST;
      id_d    = cmd_id;
      addr_d  = cmd_addr;
      base_d  = cmd_addr;
      len_d   = cmd_len;
      idx_d   = '0;
      size_d  = cmd_size;
      burst_d = cmd_burst;
      last_d  = (cmd_len == '0);
    end else if (beat_hs) begin
      if (last_q) begin
        state_d = ST_IDLE;
      end else begin
        idx_d  = idx_q + AXI_LW'(1);
        addr_d = next_addr;
        last_d = ((idx_q + AXI_LW'(1)) == len_q);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

`ifdef ASI_ADDR_CHECK_EN
  localparam int LB = $clog2(SLV_BYTES);

  logic              err_q, err_d;
  logic              cmd_err;
  logic              wrap_len_ok;
  logic [AXI_AW-1:0] chk_sz;
  logic [AXI_AW-1:0] chk_span;
  logic [AXI_AW-1:0] chk_end;

  // The 4 KB test uses the last byte of the burst measured from the aligned start.
  always_comb begin
    chk_sz      = AXI_AW'(1) << cmd_size;
    chk_span    = (AXI_AW'(cmd_len) + AXI_AW'(1)) << cmd_size;
    chk_end     = (cmd_addr & ~(chk_sz - AXI_AW'(1))) + chk_span - AXI_AW'(1);
    wrap_len_ok = (cmd_len == AXI_LW'(WRAP_BL_2)) | (cmd_len == AXI_LW'(WRAP_BL_4)) |
                  (cmd_len == AXI_LW'(WRAP_BL_8)) | (cmd_len == AXI_LW'(WRAP_BL_16));
    cmd_err     = (cmd_burst == BT_RESERVED) |
                  ((cmd_burst == BT_WRAP) & ~wrap_len_ok) |
                  ((cmd_burst == BT_WRAP) & ((cmd_addr & (chk_sz - AXI_AW'(1))) != '0)) |
                  (int'(cmd_size) > LB) |
                  ((cmd_burst == BT_INCR) & (cmd_addr[AXI_AW-1:12] != chk_end[AXI_AW-1:12]));
    err_d       = cmd_hs ? cmd_err : err_q;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign beat_err = err_q;
`else
  assign beat_err = 1'b0;
`endif

endmodule

// File: tb/tb_asi_wbeat_gen.sv
// Self-checking bench for asi_wbeat_gen: directed AXI burst cases plus
// randomized commands and backpressure against a burst-level reference model.
module tb_asi_wbeat_gen;

  import asi_pkg::*;

`ifdef ASI_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam longint unsigned AMASK = (64'd1 << 40) - 64'd1;

  typedef struct packed {
    logic [7:0]  id;
    logic [39:0] addr;
    logic [15:0] mask;
    logic [7:0]  idx;
    logic        last;
    logic        err;
  } exp_t;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_id;
  logic [39:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        beat_valid;
  logic        beat_ready;
  logic [7:0]  beat_id;
  logic [39:0] beat_addr;
  logic [15:0] beat_mask;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic        beat_err;

  exp_t exp_q[$];
  exp_t obs_q[$];
  int   total = 0;
  int   bad   = 0;
  int   rdy_mode = 0;

  exp_t ch;
  exp_t ob;
  bit   ev;
  bit   er;
  bit   m_ready;

  always #5 ACLK = ~ACLK;

  asi_wbeat_gen dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_id     (cmd_id),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_size   (cmd_size),
    .cmd_burst  (cmd_burst),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_id    (beat_id),
    .beat_addr  (beat_addr),
    .beat_mask  (beat_mask),
    .beat_idx   (beat_idx),
    .beat_last  (beat_last),
    .beat_err   (beat_err)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Bytes from the start address to the end of its size container, clipped to the bus.
  function automatic logic [15:0] lane_mask(input longint unsigned a, input int size);
    longint unsigned sz, stop, bus_end;
    logic [15:0] m;
    m       = '0;
    sz      = 64'd1 << size;
    stop    = a - (a % sz) + sz;
    bus_end = a - (a % 64'd16) + 64'd16;
    if (bus_end < stop) stop = bus_end;
    for (longint unsigned b = a; b < stop; b++) m[int'(b % 64'd16)] = 1'b1;
    return m;
  endfunction

  function automatic void push_burst(input logic [7:0] id, input logic [39:0] a, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    longint unsigned sz, a0, al, wb, lower, cur, last_byte;
    exp_t e;
    logic err;
    sz        = 64'd1 << size;
    a0        = 64'(a);
    al        = a0 - (a0 % sz);
    wb        = (64'(len) + 64'd1) * sz;
    lower     = a0 & ~(wb - 64'd1);
    last_byte = (al + wb - 64'd1) & AMASK;
    err = 1'b0;
    if (CHK) begin
      if (burst == BT_RESERVED) err = 1'b1;
      if (burst == BT_WRAP && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) err = 1'b1;
      if (burst == BT_WRAP && (a0 % sz) != 0) err = 1'b1;
      if (size > 3'd4) err = 1'b1;
      if (burst == BT_INCR && (a0 >> 12) != (last_byte >> 12)) err = 1'b1;
    end
    for (int n = 0; n <= int'(len); n++) begin
      if (n == 0 || burst == BT_FIXED) cur = a0;
      else if (burst == BT_WRAP) cur = lower + ((al - lower + 64'(n) * sz) % wb);
      else cur = (al + 64'(n) * sz) & AMASK;
      e.id   = id;
      e.addr = 40'(cur);
      e.mask = lane_mask(cur, int'(size));
      e.idx  = 8'(n);
      e.last = (n == int'(len));
      e.err  = err;
      exp_q.push_back(e);
    end
  endfunction

  // Reference model advances on the same handshakes the bus would see.
  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      exp_q.delete();
    end else begin
      m_ready = (exp_q.size() == 0) || (beat_ready && exp_q[0].last);
      if (exp_q.size() != 0 && beat_ready) void'(exp_q.pop_front());
      if (cmd_valid && m_ready) push_burst(cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst);
    end
  end

  always @(negedge ACLK) begin
    if (ARESETn) begin
      ev = (exp_q.size() != 0);
      er = !ev || (beat_ready && exp_q[0].last);
      check_output("beat_valid", 64'(beat_valid), 64'(ev));
      check_output("cmd_ready", 64'(cmd_ready), 64'(er));
      if (ev && beat_valid) begin
        ch = exp_q[0];
        check_output("beat_id", 64'(beat_id), 64'(ch.id));
        check_output("beat_addr", 64'(beat_addr), 64'(ch.addr));
        check_output("beat_mask", 64'(beat_mask), 64'(ch.mask));
        check_output("beat_idx", 64'(beat_idx), 64'(ch.idx));
        check_output("beat_last", 64'(beat_last), 64'(ch.last));
        check_output("beat_err", 64'(beat_err), 64'(ch.err));
      end else begin
        check_output("idle_mask", 64'(beat_mask), 64'd0);
      end
      if (beat_valid && beat_ready) begin
        ob.id   = beat_id;
        ob.addr = beat_addr;
        ob.mask = beat_mask;
        ob.idx  = beat_idx;
        ob.last = beat_last;
        ob.err  = beat_err;
        obs_q.push_back(ob);
      end
    end
  end

  initial begin
    forever begin
      @(posedge ACLK);
      #2;
      case (rdy_mode)
        0:       beat_ready = 1'b1;
        1:       beat_ready = ~beat_ready;
        default: beat_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic sync();
    @(posedge ACLK);
    #2;
  endtask

  task automatic apply_stimulus(input logic [7:0] id, input logic [39:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst);
    int n;
    n         = 0;
    cmd_id    = id;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_size  = size;
    cmd_burst = burst;
    cmd_valid = 1'b1;
    forever begin
      @(negedge ACLK);
      if (cmd_ready) break;
      n++;
      if (n > 500) begin
        total++;
        bad++;
        $display("[TB] FAIL cmd_accept_timeout: got no cmd_ready required cmd_ready=1 within 500 cycles");
        break;
      end
    end
    sync();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n);
    int c;
    c = 0;
    while (obs_q.size() < n && c < 1000) begin
      @(negedge ACLK);
      #1;
      c++;
    end
    if (obs_q.size() < n) begin
      total++;
      bad++;
      $display("[TB] FAIL beat_timeout: got %0d beats required %0d", obs_q.size(), n);
    end
    sync();
  endtask

  task automatic check_beat(input int i, input string tag, input logic [39:0] a, input logic [15:0] m,
                            input logic [7:0] id, input int idx, input bit last, input bit err);
    exp_t o;
    if (obs_q.size() <= i) begin
      total++;
      bad++;
      $display("[TB] FAIL %s%0d_missing: got %0d beats required more than %0d", tag, i, obs_q.size(), i);
    end else begin
      o = obs_q[i];
      check_output($sformatf("%s%0d_addr", tag, i), 64'(o.addr), 64'(a));
      check_output($sformatf("%s%0d_mask", tag, i), 64'(o.mask), 64'(m));
      check_output($sformatf("%s%0d_id", tag, i), 64'(o.id), 64'(id));
      check_output($sformatf("%s%0d_idx", tag, i), 64'(o.idx), 64'(idx));
      check_output($sformatf("%s%0d_last", tag, i), 64'(o.last), 64'(last));
      check_output($sformatf("%s%0d_err", tag, i), 64'(o.err), 64'(err));
    end
  endtask

  logic [39:0] wa[4];
  logic [15:0] wm[4];
  logic [39:0] r_addr;
  logic [7:0]  r_len;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  int          drain;

  initial begin
    ARESETn    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_id     = '0;
    cmd_addr   = '0;
    cmd_len    = '0;
    cmd_size   = '0;
    cmd_burst  = '0;
    beat_ready = 1'b1;
    rdy_mode   = 0;

    repeat (2) @(negedge ACLK);
    check_output("rst_valid", 64'(beat_valid), 64'd0);
    check_output("rst_ready", 64'(cmd_ready), 64'd1);
    check_output("rst_addr", 64'(beat_addr), 64'd0);
    check_output("rst_mask", 64'(beat_mask), 64'd0);
    check_output("rst_idx", 64'(beat_idx), 64'd0);
    check_output("rst_last", 64'(beat_last), 64'd0);
    check_output("rst_err", 64'(beat_err), 64'd0);
    check_output("rst_id", 64'(beat_id), 64'd0);
    sync();
    ARESETn = 1'b1;
    sync();

    $display("[TB] INCR aligned burst");
    obs_q.delete();
    apply_stimulus(8'h11, 40'h1000, 8'd3, 3'd4, BT_INCR);
    wait_obs(4);
    for (int i = 0; i < 4; i++)
      check_beat(i, "incr", 40'h1000 + 40'(16 * i), 16'hFFFF, 8'h11, i, (i == 3), 1'b0);

    $display("[TB] WRAP burst");
    wa[0] = 40'h1038; wa[1] = 40'h1020; wa[2] = 40'h1028; wa[3] = 40'h1030;
    wm[0] = 16'hFF00; wm[1] = 16'h00FF; wm[2] = 16'hFF00; wm[3] = 16'h00FF;
    obs_q.delete();
    apply_stimulus(8'h22, 40'h1038, 8'd3, 3'd3, BT_WRAP);
    wait_obs(4);
    for (int i = 0; i < 4; i++) check_beat(i, "wrap", wa[i], wm[i], 8'h22, i, (i == 3), 1'b0);

    $display("[TB] narrow unaligned INCR and FIXED");
    obs_q.delete();
    apply_stimulus(8'h33, 40'h1005, 8'd1, 3'd2, BT_INCR);
    wait_obs(2);
    check_beat(0, "narrow", 40'h1005, 16'h00E0, 8'h33, 0, 1'b0, 1'b0);
    check_beat(1, "narrow", 40'h1008, 16'h0F00, 8'h33, 1, 1'b1, 1'b0);
    obs_q.delete();
    apply_stimulus(8'h34, 40'h1005, 8'd1, 3'd2, BT_FIXED);
    wait_obs(2);
    check_beat(0, "fixed", 40'h1005, 16'h00E0, 8'h34, 0, 1'b0, 1'b0);
    check_beat(1, "fixed", 40'h1005, 16'h00E0, 8'h34, 1, 1'b1, 1'b0);

    $display("[TB] back-to-back with toggling beat_ready");
    rdy_mode = 1;
    obs_q.delete();
    apply_stimulus(8'h05, 40'h3000, 8'd1, 3'd4, BT_INCR);
    apply_stimulus(8'h06, 40'h4000, 8'd1, 3'd4, BT_INCR);
    wait_obs(4);
    check_beat(0, "b2b", 40'h3000, 16'hFFFF, 8'h05, 0, 1'b0, 1'b0);
    check_beat(1, "b2b", 40'h3010, 16'hFFFF, 8'h05, 1, 1'b1, 1'b0);
    check_beat(2, "b2b", 40'h4000, 16'hFFFF, 8'h06, 0, 1'b0, 1'b0);
    check_beat(3, "b2b", 40'h4010, 16'hFFFF, 8'h06, 1, 1'b1, 1'b0);
    rdy_mode = 0;
    sync();

    $display("[TB] error cases");
    obs_q.delete();
    apply_stimulus(8'h44, 40'h1000, 8'd2, 3'd2, BT_WRAP);
    wait_obs(3);
    check_beat(0, "wrap3", 40'h1000, 16'h000F, 8'h44, 0, 1'b0, CHK);
    check_beat(1, "wrap3", 40'h1004, 16'h00F0, 8'h44, 1, 1'b0, CHK);
    check_beat(2, "wrap3", 40'h1008, 16'h0F00, 8'h44, 2, 1'b1, CHK);
    obs_q.delete();
    apply_stimulus(8'h55, 40'h1FF0, 8'd1, 3'd4, BT_INCR);
    wait_obs(2);
    check_beat(0, "x4k", 40'h1FF0, 16'hFFFF, 8'h55, 0, 1'b0, CHK);
    check_beat(1, "x4k", 40'h2000, 16'hFFFF, 8'h55, 1, 1'b1, CHK);
    obs_q.delete();
    apply_stimulus(8'h66, 40'hFF_FFFF_FFF0, 8'd1, 3'd4, BT_INCR);
    wait_obs(2);
    check_beat(0, "top", 40'hFF_FFFF_FFF0, 16'hFFFF, 8'h66, 0, 1'b0, CHK);
    check_beat(1, "top", 40'h0, 16'hFFFF, 8'h66, 1, 1'b1, CHK);

    $display("[TB] reset during a burst");
    obs_q.delete();
    apply_stimulus(8'h77, 40'h5000, 8'd7, 3'd4, BT_INCR);
    wait_obs(2);
    ARESETn = 1'b0;
    #1;
    check_output("rst_mid_valid", 64'(beat_valid), 64'd0);
    check_output("rst_mid_idx", 64'(beat_idx), 64'd0);
    repeat (2) @(posedge ACLK);
    #2;
    ARESETn = 1'b1;
    @(negedge ACLK);
    check_output("rst_rel_ready", 64'(cmd_ready), 64'd1);
    sync();
    obs_q.delete();
    apply_stimulus(8'h88, 40'h6000, 8'd1, 3'd4, BT_INCR);
    wait_obs(2);
    check_beat(0, "post_rst", 40'h6000, 16'hFFFF, 8'h88, 0, 1'b0, 1'b0);
    check_beat(1, "post_rst", 40'h6010, 16'hFFFF, 8'h88, 1, 1'b1, 1'b0);

    $display("[TB] randomized commands");
    rdy_mode = 2;
    for (int k = 0; k < 300; k++) begin
      r_burst = 2'($urandom_range(0, 3));
      r_size  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
      r_addr  = {8'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) r_addr[11:4] = 8'hFF;
      if ($urandom_range(0, 2) == 0) r_addr = r_addr & ~((40'd1 << r_size) - 40'd1);
      if (r_burst == BT_WRAP) begin
        case ($urandom_range(0, 3))
          0:       r_len = 8'd1;
          1:       r_len = 8'd3;
          2:       r_len = 8'd7;
          default: r_len = 8'd15;
        endcase
      end else if ($urandom_range(0, 3) == 0) begin
        r_len = 8'($urandom_range(16, 40));
      end else begin
        r_len = 8'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) sync();
      apply_stimulus(8'(k), r_addr, r_len, r_size, r_burst);
    end

    drain = 0;
    while (exp_q.size() != 0 && drain < 5000) begin
      @(negedge ACLK);
      drain++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: got %0d beats outstanding required 0", exp_q.size());
    end
    repeat (3) @(negedge ACLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
